// File: rtl/credit_issue_queue_if.sv
// rtl/credit_issue_queue_if.sv - handshake bundle between the issue queue and its neighbours
// Purpose: groups the enqueue, issue, credit-spend, credit-flush and
//   credit-return signals of credit_issue_queue.
// Ports (signals):
//   enq__ENA / enq_v / enq__RDY                 request enqueue {payload, len}
//   out__ENA / out_v / out__RDY                 downstream issue of head payload
//   maybeDecrement__ENA / maybeDecrement_v /
//   maybeDecrement                              credit spend attempt and grant
//   increment__ENA / increment_v                batched credit flush
//   creditReturn__ENA / creditReturn_v /
//   creditReturn__RDY                           downstream credit return
// Modports: master = the queue itself, slave = its environment.
interface credit_issue_queue_if #(
  parameter int count_sz = 10,
  parameter int DATA_W   = 32
);
  logic                       enq__ENA;
  logic [DATA_W+count_sz-1:0] enq_v;
  logic                       enq__RDY;
  logic                       out__ENA;
  logic [DATA_W-1:0]          out_v;
  logic                       out__RDY;
  logic                       maybeDecrement__ENA;
  logic [count_sz-1:0]        maybeDecrement_v;
  logic                       maybeDecrement;
  logic                       increment__ENA;
  logic [count_sz-1:0]        increment_v;
  logic                       creditReturn__ENA;
  logic [count_sz-1:0]        creditReturn_v;
  logic                       creditReturn__RDY;

  modport master (
    input  enq__ENA, enq_v, out__RDY, maybeDecrement,
           creditReturn__ENA, creditReturn_v,
    output enq__RDY, out__ENA, out_v, maybeDecrement__ENA, maybeDecrement_v,
           increment__ENA, increment_v, creditReturn__RDY
  );

  modport slave (
    output enq__ENA, enq_v, out__RDY, maybeDecrement,
           creditReturn__ENA, creditReturn_v,
    input  enq__RDY, out__ENA, out_v, maybeDecrement__ENA, maybeDecrement_v,
           increment__ENA, increment_v, creditReturn__RDY
  );
endinterface

// File: rtl/credit_issue_queue.sv
// rtl/credit_issue_queue.sv - credit-gated issue FIFO with batched credit return
// Purpose: buffers length-tagged requests, spends credits for the head entry
//   through the counter's maybeDecrement method and issues it downstream only
//   on grant; accumulates downstream credit returns and flushes them to the
//   counter as increment calls (threshold or timeout).
// Ports:
//   CLK   clock, all state on posedge
//   nRST  asynchronous active-low reset
//   q     credit_issue_queue_if.master (enq, out, maybeDecrement, increment,
//         creditReturn handshakes)
// Optional feature: define CREDIT_ISSUE_BYPASS_EN for a zero-latency path from
//   enq to out when the FIFO is empty. Default build keeps a registered
//   1-cycle minimum latency with no enq->out combinational path.
module credit_issue_queue #(
  parameter int count_sz     = 10,
  parameter int DATA_W       = 32,
  parameter int DEPTH        = 4,
  parameter int FLUSH_THRESH = 8,
  parameter int FLUSH_TMO    = 16
) (
  input logic                  CLK,
  input logic                  nRST,
  credit_issue_queue_if.master q
);
  localparam int EW = DATA_W + count_sz;
  localparam int AW = $clog2(DEPTH);
  localparam int TW = (FLUSH_TMO > 1) ? $clog2(FLUSH_TMO) : 1;
  localparam logic [count_sz-1:0] THRESH   = count_sz'(FLUSH_THRESH);
  localparam logic [TW-1:0]       TMO_LAST = TW'(FLUSH_TMO - 1);

  logic [EW-1:0]       mem [DEPTH];
  logic [AW:0]         wr_ptr;
  logic [AW:0]         rd_ptr;
  logic                empty;
  logic                full;
  logic                bypass;
  logic                md_ena;
  logic                fire;
  logic                pop;
  logic                push;
  logic [EW-1:0]       head;
  logic [count_sz-1:0] acc;
  logic [TW-1:0]       timer;
  logic                flush;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

`ifdef CREDIT_ISSUE_BYPASS_EN
  assign bypass = empty && q.enq__ENA;
`else
  assign bypass = 1'b0;
`endif

  assign head   = bypass ? q.enq_v : mem[rd_ptr[AW-1:0]];
  assign md_ena = (!empty || bypass) && q.out__RDY;
  assign fire   = md_ena && q.maybeDecrement;
  // A bypassed entry issued this cycle is never written into the FIFO.
  assign pop    = fire && !bypass;
  // Enqueue into a full FIFO is accepted only when the head leaves this cycle.
  assign push   = q.enq__ENA && (!full || pop) && !(bypass && fire);

  assign q.enq__RDY            = !full;
  assign q.maybeDecrement__ENA = md_ena;
  assign q.maybeDecrement_v    = head[count_sz-1:0];
  assign q.out__ENA            = fire;
  assign q.out_v               = head[EW-1:count_sz];

  assign flush = (acc >= THRESH) || ((acc != '0) && (timer == TMO_LAST));

  assign q.increment__ENA    = flush;
  assign q.increment_v       = acc;
  // Any return is safe to absorb only when acc is empty or is being drained now.
  assign q.creditReturn__RDY = (acc == '0) || flush;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr[AW-1:0]] <= q.enq_v;
  end

  // A return arriving in a flush cycle is excluded from the flushed value and
  // starts the next batch with a fresh timer.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      acc   <= '0;
      timer <= '0;
    end else begin
      if (flush)
        acc <= q.creditReturn__ENA ? q.creditReturn_v : '0;
      else if (q.creditReturn__ENA)
        acc <= acc + q.creditReturn_v;

      if (flush || (acc == '0))
        timer <= '0;
      else if (timer != TMO_LAST)
        timer <= timer + TW'(1);
    end
  end
endmodule

// File: tb/tb_credit_issue_queue.sv
// tb/tb_credit_issue_queue.sv - scoreboard bench for credit_issue_queue
module tb_credit_issue_queue;
  logic CLK = 1'b0;
  logic nRST = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] cnt = 16'd10;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_out[$];
  exp_t exp_inc[$];

  credit_issue_queue_if #(.count_sz(10), .DATA_W(32)) bus ();

  credit_issue_queue #(
    .count_sz(10), .DATA_W(32), .DEPTH(4), .FLUSH_THRESH(8), .FLUSH_TMO(16)
  ) dut (
    .CLK(CLK),
    .nRST(nRST),
    .q(bus)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Credit counter stand-in: grant when enough credits, net spend and return.
  assign bus.maybeDecrement = (cnt >= {6'd0, bus.maybeDecrement_v});
  always @(posedge CLK) begin
    cnt <= cnt - (bus.out__ENA ? {6'd0, bus.maybeDecrement_v} : 16'd0)
               + (bus.increment__ENA ? {6'd0, bus.increment_v} : 16'd0);
  end

  always @(negedge CLK) begin
    exp_t e;
    if (nRST) begin
      if (bus.out__ENA) begin
        checks++;
        if (exp_out.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected got %h at cycle %0d", bus.out_v, cyc);
        end else begin
          e = exp_out.pop_front();
          if (bus.out_v !== e.data || cyc != e.cyc) begin
            errors++;
            $display("FAIL out_issue got %h@%0d expected %h@%0d",
                     bus.out_v, cyc, e.data, e.cyc);
          end
        end
      end
      if (bus.increment__ENA) begin
        checks++;
        if (exp_inc.size() == 0) begin
          errors++;
          $display("FAIL inc_unexpected got %0d at cycle %0d", bus.increment_v, cyc);
        end else begin
          e = exp_inc.pop_front();
          if ({22'd0, bus.increment_v} !== e.data || cyc != e.cyc) begin
            errors++;
            $display("FAIL increment got %0d@%0d expected %0d@%0d",
                     bus.increment_v, cyc, e.data, e.cyc);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_out(input logic [31:0] d, input int c);
    exp_t e;
    e.data = d;
    e.cyc  = c;
    exp_out.push_back(e);
  endtask

  task automatic push_inc(input logic [31:0] d, input int c);
    exp_t e;
    e.data = d;
    e.cyc  = c;
    exp_inc.push_back(e);
  endtask

  initial begin
    int c0;
    int r;
    int s;
    int u;
    bus.enq__ENA = 1'b0;
    bus.enq_v = '0;
    bus.out__RDY = 1'b0;
    bus.creditReturn__ENA = 1'b0;
    bus.creditReturn_v = '0;

    // Reset state
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_enq_rdy", {31'd0, bus.enq__RDY}, 32'd1);
    chk("rst_ret_rdy", {31'd0, bus.creditReturn__RDY}, 32'd1);
    chk("rst_out_ena", {31'd0, bus.out__ENA}, 32'd0);
    chk("rst_md_ena", {31'd0, bus.maybeDecrement__ENA}, 32'd0);
    chk("rst_inc_ena", {31'd0, bus.increment__ENA}, 32'd0);
    tick();
    nRST = 1'b1;

    // Three len=4 requests against 10 credits: two issue, third held
    tick();
    bus.out__RDY = 1'b1;
    bus.enq__ENA = 1'b1;
    bus.enq_v = {32'h0000_00A1, 10'd4};
    c0 = cyc;
    push_out(32'h0000_00A1, c0 + 1);
    tick();
    bus.enq_v = {32'h0000_00A2, 10'd4};
    push_out(32'h0000_00A2, c0 + 2);
    tick();
    bus.enq_v = {32'h0000_00A3, 10'd4};
    tick();
    bus.enq__ENA = 1'b0;
    @(negedge CLK);
    chk("held_md_ena", {31'd0, bus.maybeDecrement__ENA}, 32'd1);
    chk("held_grant", {31'd0, bus.maybeDecrement}, 32'd0);
    chk("held_out_ena", {31'd0, bus.out__ENA}, 32'd0);
    chk("held_md_len", {22'd0, bus.maybeDecrement_v}, 32'd4);

    // Single return of 2 flushes by timeout and unblocks the held entry
    tick();
    bus.creditReturn__ENA = 1'b1;
    bus.creditReturn_v = 10'd2;
    r = cyc;
    push_inc(32'd2, r + 16);
    push_out(32'h0000_00A3, r + 17);
    tick();
    bus.creditReturn__ENA = 1'b0;
    repeat (20) tick();

    // Fill the FIFO with out__RDY low; fifth enqueue is dropped
    bus.out__RDY = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.enq__ENA = 1'b1;
      bus.enq_v = {32'h0000_00B0 + 32'(i), 10'd1};
    end
    tick();
    bus.enq_v = {32'h0000_00B5, 10'd1};
    @(negedge CLK);
    chk("full_enq_rdy", {31'd0, bus.enq__RDY}, 32'd0);
    tick();
    bus.enq__ENA = 1'b0;

    // Returns 3,3,3 -> threshold flush of 9; return 5 lands in the flush cycle
    tick();
    bus.creditReturn__ENA = 1'b1;
    bus.creditReturn_v = 10'd3;
    s = cyc;
    tick();
    @(negedge CLK);
    chk("acc_ret_rdy_low", {31'd0, bus.creditReturn__RDY}, 32'd0);
    tick();
    tick();
    bus.creditReturn_v = 10'd5;
    push_inc(32'd9, s + 3);
    push_inc(32'd5, s + 19);
    @(negedge CLK);
    chk("flush_ret_rdy", {31'd0, bus.creditReturn__RDY}, 32'd1);
    tick();
    bus.creditReturn__ENA = 1'b0;
    repeat (20) tick();

    // Drain the full FIFO in order
    tick();
    bus.out__RDY = 1'b1;
    u = cyc;
    for (int i = 0; i < 4; i++) push_out(32'h0000_00B0 + 32'(i), u + i);
    repeat (5) tick();
    @(negedge CLK);
    chk("drain_enq_rdy", {31'd0, bus.enq__RDY}, 32'd1);

    // len=0 issues like any other entry
    tick();
    bus.enq__ENA = 1'b1;
    bus.enq_v = {32'h0000_00E1, 10'd0};
    push_out(32'h0000_00E1, cyc + 1);
    tick();
    bus.enq__ENA = 1'b0;
    tick();

    // Reset mid-operation: two ungrantable entries queued, acc=3
    tick();
    bus.enq__ENA = 1'b1;
    bus.enq_v = {32'h0000_00D1, 10'd20};
    tick();
    bus.enq_v = {32'h0000_00D2, 10'd20};
    tick();
    bus.enq__ENA = 1'b0;
    bus.creditReturn__ENA = 1'b1;
    bus.creditReturn_v = 10'd3;
    tick();
    bus.creditReturn__ENA = 1'b0;
    @(negedge CLK);
    chk("pre_rst_md_ena", {31'd0, bus.maybeDecrement__ENA}, 32'd1);
    chk("pre_rst_ret_rdy", {31'd0, bus.creditReturn__RDY}, 32'd0);
    tick();
    nRST = 1'b0;
    #1;
    chk("mid_rst_md_ena", {31'd0, bus.maybeDecrement__ENA}, 32'd0);
    chk("mid_rst_out_ena", {31'd0, bus.out__ENA}, 32'd0);
    chk("mid_rst_inc_ena", {31'd0, bus.increment__ENA}, 32'd0);
    chk("mid_rst_enq_rdy", {31'd0, bus.enq__RDY}, 32'd1);
    chk("mid_rst_ret_rdy", {31'd0, bus.creditReturn__RDY}, 32'd1);
    repeat (2) tick();
    nRST = 1'b1;
    repeat (25) tick();
    @(negedge CLK);
    chk("post_rst_md_ena", {31'd0, bus.maybeDecrement__ENA}, 32'd0);
    chk("post_rst_ret_rdy", {31'd0, bus.creditReturn__RDY}, 32'd1);

    chk("out_left", 32'(exp_out.size()), 32'd0);
    chk("inc_left", 32'(exp_inc.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
